core_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32I core. Sequences each instruction through fetch, decode, execute, memory and write-back. Drives the instruction-memory and data-memory request handshakes and the PC, instruction-register and register-file write enables. Qualifies the decoder's `we3`/`wem`/`wd3_selector` so that architectural state is written only once per instruction. Sits between the decoder/ALU datapath and the two memory ports, and also maintains the cycle and retired-instruction counters and the halt/fault status.

---
 rtl/core_sequencer_pkg.sv | 44 ++++
 rtl/core_sequencer_bus_watchdog.sv | 36 +++
 rtl/core_sequencer.sv | 161 ++++++++++++++++
 tb/tb_core_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the RV32I multi-cycle core: sequencer states, halt causes
// and the major opcode map used by both the sequencer and the decoder.
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_SYS     = 2'b01,
    FAULT_ILLEGAL = 2'b10,
    FAULT_TIMEOUT = 2'b11
  } fault_t;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_REG      = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  function automatic logic is_rv32i_opcode(input logic [6:0] op);
    logic legal;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_REG, OP_MISC_MEM, OP_SYSTEM: legal = 1'b1;
      default:                                          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/core_sequencer_bus_watchdog.sv
// Clearable wait-cycle counter for the memory handshakes; expired flags the cycle in
// which the number of cycles spent waiting (current one included) reaches TIMEOUT.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [31:0] count_reg;
  logic [31:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (en) begin
      count_next = count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // TIMEOUT of zero disables the watchdog entirely
  assign expired = en && (TIMEOUT != 0) && ((count_reg + 32'd1) == 32'(TIMEOUT));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control, memory request
// handshakes, single-shot architectural write strobes, counters and halt status.
module core_sequencer
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        we3,
  input  logic        wem,
  input  logic        wd3_selector,
  input  logic        redirect,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        ir_we,
  output logic        alu_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        halted,
  output logic [1:0]  fault,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  state_t      state_reg, state_next;
  fault_t      fault_reg, fault_next;
  logic        we3_reg, wem_reg, sel_reg, redirect_reg;
  logic        imem_req_reg, dmem_req_reg, dmem_we_reg;
  logic [31:0] cycle_cnt_reg, instret_cnt_reg;
  logic        wd_en, wd_expired, retire;
  logic        is_fence;

  assign wd_en    = imem_req_reg | dmem_req_reg;
  assign is_fence = (opcode == OP_MISC_MEM);

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!wd_en),
    .en     (wd_en),
    .expired(wd_expired)
  );

  always_comb begin
    state_next = state_reg;
    fault_next = fault_reg;
    ir_we      = 1'b0;
    alu_we     = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    retire     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (run) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        // a ready in the expiry cycle still completes the fetch
        if (imem_ready) begin
          ir_we      = 1'b1;
          state_next = ST_DECODE;
        end else if (wd_expired) begin
          state_next = ST_HALT;
          fault_next = FAULT_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (opcode == OP_SYSTEM) begin
          state_next = ST_HALT;
          fault_next = FAULT_SYS;
        end else if (!is_rv32i_opcode(opcode)) begin
          state_next = ST_HALT;
          fault_next = FAULT_ILLEGAL;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_we     = 1'b1;
        state_next = (sel_reg || wem_reg) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (dmem_ready) begin
          state_next = ST_WB;
        end else if (wd_expired) begin
          state_next = ST_HALT;
          fault_next = FAULT_TIMEOUT;
        end
      end
      ST_WB: begin
        rf_we      = we3_reg;
        pc_we      = 1'b1;
        pc_sel     = redirect_reg;
        retire     = 1'b1;
        state_next = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      fault_reg       <= FAULT_NONE;
      we3_reg         <= 1'b0;
      wem_reg         <= 1'b0;
      sel_reg         <= 1'b0;
      redirect_reg    <= 1'b0;
      imem_req_reg    <= 1'b0;
      dmem_req_reg    <= 1'b0;
      dmem_we_reg     <= 1'b0;
      cycle_cnt_reg   <= '0;
      instret_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      fault_reg    <= fault_next;
      // requests are flops fed from the next state, so ready never reaches req combinationally
      imem_req_reg <= (state_next == ST_FETCH);
      dmem_req_reg <= (state_next == ST_MEM);
      dmem_we_reg  <= (state_next == ST_MEM) && wem_reg;
      if (state_reg == ST_DECODE) begin
        // FENCE is retired as a NOP regardless of what the decoder asserts
        we3_reg <= we3 && !is_fence;
        wem_reg <= wem && !is_fence;
        sel_reg <= wd3_selector && !is_fence;
      end
      if (state_reg == ST_EXEC) begin
        redirect_reg <= redirect;
      end
      if (state_reg != ST_IDLE && state_reg != ST_HALT) begin
        cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      end
      if (retire) begin
        instret_cnt_reg <= instret_cnt_reg + 32'd1;
      end
    end
  end

  assign imem_req    = imem_req_reg;
  assign dmem_req    = dmem_req_reg;
  assign dmem_we     = dmem_we_reg;
  assign halted      = (state_reg == ST_HALT);
  assign fault       = fault_reg;
  assign cycle_cnt   = cycle_cnt_reg;
  assign instret_cnt = instret_cnt_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed-vector bench for core_sequencer: walks each instruction cycle by cycle and
// compares every strobe and counter against hand-derived values.
module tb_core_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [6:0]  opcode;
  logic        we3, wem, wd3_selector, redirect;
  logic        imem_req, imem_ready;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        ir_we, alu_we, rf_we, pc_we, pc_sel, halted;
  logic [1:0]  fault;
  logic [31:0] cycle_cnt, instret_cnt;

  int tests_run = 0;
  int failures  = 0;

  core_sequencer #(
    .TIMEOUT(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .opcode      (opcode),
    .we3         (we3),
    .wem         (wem),
    .wd3_selector(wd3_selector),
    .redirect    (redirect),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ready  (dmem_ready),
    .ir_we       (ir_we),
    .alu_we      (alu_we),
    .rf_we       (rf_we),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .halted      (halted),
    .fault       (fault),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; settle lets combinational outputs follow new inputs.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0; run = 1'b0; opcode = '0;
    we3 = 1'b0; wem = 1'b0; wd3_selector = 1'b0; redirect = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    cyc(); cyc(); settle();
    check({tag, "/strobes"},
          {23'd0, imem_req, dmem_req, dmem_we, ir_we, alu_we, rf_we, pc_we, pc_sel, halted}, 32'd0);
    check({tag, "/fault"}, {30'd0, fault}, 32'd0);
    check({tag, "/cycle_cnt"}, cycle_cnt, 32'd0);
    check({tag, "/instret_cnt"}, instret_cnt, 32'd0);
    rst_n = 1'b1;
    $display("[TB] reset %s", tag);
  endtask

  // One instruction launched from IDLE; decoder inputs are flipped after they should have
  // been latched so that any use of the live values shows up as a wrong strobe.
  task automatic do_instr(input string tag, input logic [6:0] op,
                          input logic w3, input logic wm, input logic sel, input logic rd,
                          input int imem_wait, input int mem_wait,
                          input logic exp_mem, input logic exp_rf);
    logic [31:0] cyc0, ret0;
    int          mem_cycles;
    int          total;
    cyc0 = cycle_cnt;
    ret0 = instret_cnt;
    mem_cycles = exp_mem ? mem_wait + 1 : 0;
    opcode = op; we3 = w3; wem = wm; wd3_selector = sel; redirect = rd;
    run = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b1;
    settle();
    check({tag, "/idle_imem_req"}, {31'd0, imem_req}, 32'd0);
    total = 1;
    for (int k = 0; k <= imem_wait; k++) begin
      cyc();
      imem_ready = (k == imem_wait);
      settle();
      total++;
      check({tag, "/fetch_imem_req"}, {31'd0, imem_req}, 32'd1);
      check({tag, "/fetch_ir_we"}, {31'd0, ir_we}, {31'd0, (k == imem_wait)});
    end
    cyc(); settle(); total++;
    check({tag, "/decode_imem_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "/decode_ir_we"}, {31'd0, ir_we}, 32'd0);
    check({tag, "/decode_halted"}, {31'd0, halted}, 32'd0);
    cyc();
    we3 = ~w3; wem = ~wm; wd3_selector = ~sel;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    settle(); total++;
    check({tag, "/exec_alu_we"}, {31'd0, alu_we}, 32'd1);
    check({tag, "/exec_dmem_req"}, {31'd0, dmem_req}, 32'd0);
    for (int k = 0; k < mem_cycles; k++) begin
      cyc();
      dmem_ready = (k == mem_cycles - 1);
      settle();
      total++;
      check({tag, "/mem_dmem_req"}, {31'd0, dmem_req}, 32'd1);
      check({tag, "/mem_dmem_we"}, {31'd0, dmem_we}, {31'd0, wm});
      check({tag, "/mem_rf_we"}, {31'd0, rf_we}, 32'd0);
    end
    cyc();
    dmem_ready = 1'b0; redirect = ~rd; run = 1'b0;
    settle(); total++;
    check({tag, "/wb_rf_we"}, {31'd0, rf_we}, {31'd0, exp_rf});
    check({tag, "/wb_pc_we"}, {31'd0, pc_we}, 32'd1);
    check({tag, "/wb_pc_sel"}, {31'd0, pc_sel}, {31'd0, rd});
    check({tag, "/wb_dmem_req"}, {31'd0, dmem_req}, 32'd0);
    cyc(); settle();
    check({tag, "/idle_pc_we"}, {31'd0, pc_we}, 32'd0);
    check({tag, "/idle_rf_we"}, {31'd0, rf_we}, 32'd0);
    check({tag, "/instret"}, instret_cnt, ret0 + 32'd1);
    check({tag, "/cycle_cnt"}, cycle_cnt, cyc0 + 32'(imem_wait + 4 + mem_cycles));
    $display("[TB] %s op=%b retired in %0d cycles instret=%0d cycle_cnt=%0d",
             tag, op, total, instret_cnt, cycle_cnt);
  endtask

  task automatic do_halt(input string tag, input logic [6:0] op, input logic [1:0] exp_fault);
    do_reset({tag, "_rst"});
    opcode = op; we3 = 1'b1; run = 1'b1; imem_ready = 1'b1;
    cyc(); cyc(); settle();
    check({tag, "/decode_halted"}, {31'd0, halted}, 32'd0);
    cyc(); settle();
    check({tag, "/halted"}, {31'd0, halted}, 32'd1);
    check({tag, "/fault"}, {30'd0, fault}, {30'd0, exp_fault});
    for (int i = 0; i < 4; i++) begin
      run = (i % 2 == 0);
      cyc(); settle();
      check({tag, "/hold_halted"}, {31'd0, halted}, 32'd1);
      check({tag, "/hold_strobes"}, {28'd0, imem_req, rf_we, pc_we, ir_we}, 32'd0);
    end
    check({tag, "/fault_held"}, {30'd0, fault}, {30'd0, exp_fault});
    check({tag, "/cycle_cnt"}, cycle_cnt, 32'd2);
    check({tag, "/instret"}, instret_cnt, 32'd0);
    $display("[TB] %s op=%b halted=%0d fault=%b", tag, op, halted, fault);
  endtask

  initial begin
    do_reset("power_on");
    do_instr("addi", 7'b0010011, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    check("addi/instret_abs", instret_cnt, 32'd1);
    check("addi/cycle_abs", cycle_cnt, 32'd4);
    do_instr("lw", 7'b0000011, 1'b1, 1'b0, 1'b1, 1'b0, 0, 3, 1'b1, 1'b1);
    check("lw/instret_abs", instret_cnt, 32'd2);
    check("lw/cycle_abs", cycle_cnt, 32'd12);

    do_reset("pre_sw");
    do_instr("sw", 7'b0100011, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    do_instr("beq", 7'b1100011, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    check("sw_beq/instret_abs", instret_cnt, 32'd2);
    do_instr("fence", 7'b0001111, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    do_instr("addi_ready_at_limit", 7'b0010011, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0, 1'b0, 1'b1);

    do_halt("ecall", 7'b1110011, 2'b01);
    do_halt("illegal", 7'b1111111, 2'b10);

    do_reset("pre_timeout");
    run = 1'b1; imem_ready = 1'b0; opcode = 7'b0010011;
    for (int k = 1; k <= 4; k++) begin
      cyc(); settle();
      check("timeout/wait_imem_req", {31'd0, imem_req}, 32'd1);
      check("timeout/wait_halted", {31'd0, halted}, 32'd0);
    end
    cyc(); settle();
    check("timeout/halted", {31'd0, halted}, 32'd1);
    check("timeout/fault", {30'd0, fault}, 32'd3);
    check("timeout/imem_req", {31'd0, imem_req}, 32'd0);
    check("timeout/cycle_cnt", cycle_cnt, 32'd4);
    $display("[TB] fetch timeout halted=%0d fault=%b", halted, fault);

    do_reset("pre_mem_reset");
    opcode = 7'b0000011; we3 = 1'b1; wd3_selector = 1'b1; run = 1'b1; imem_ready = 1'b1;
    cyc(); cyc(); cyc();
    imem_ready = 1'b0;
    cyc(); settle();
    check("mem_reset/dmem_req_before", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    cyc(); settle();
    check("mem_reset/dmem_req", {31'd0, dmem_req}, 32'd0);
    check("mem_reset/rf_we", {31'd0, rf_we}, 32'd0);
    check("mem_reset/cycle_cnt", cycle_cnt, 32'd0);
    check("mem_reset/instret", instret_cnt, 32'd0);
    rst_n = 1'b1; run = 1'b0; dmem_ready = 1'b1;
    cyc(); settle();
    check("mem_reset/idle_strobes", {29'd0, imem_req, rf_we, pc_we}, 32'd0);
    check("mem_reset/idle_cycle_cnt", cycle_cnt, 32'd0);
    $display("[TB] reset during MEM wait dmem_req=%0d cycle_cnt=%0d", dmem_req, cycle_cnt);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
